// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types and helpers for the multi-port register file
package reg_file_mp_pkg;

  typedef enum logic [3:0] {
    XCPT_NONE      = 4'd0,
    XCPT_ITLB_MISS = 4'd1,
    XCPT_DTLB_MISS = 4'd2,
    XCPT_ILLEGAL   = 4'd3,
    XCPT_SYSCALL   = 4'd4,
    XCPT_MISALIGN  = 4'd5,
    XCPT_BUS_ERR   = 4'd6
  } xcpt_type_t;

  typedef enum logic {
    PRIV_USER       = 1'b0,
    PRIV_SUPERVISOR = 1'b1
  } priv_mode_t;

  localparam priv_mode_t PRIV_RESET = PRIV_SUPERVISOR;

  // Address width exceeds the register count when NUM_REGS is not a power of two.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with alloc/release/flush and read lookup
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
  input  logic                           alloc_en_i,
  input  logic [ADDR_W-1:0]              alloc_addr_i,
  input  logic                           flush_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0]              rd_busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_RD-1:0]   wr_hit;
  logic [NUM_RD-1:0]   alloc_hit;

  function automatic logic gpr_ok(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Alloc is applied after the releases so a same-cycle producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && gpr_ok(wr_addr_i[w])) busy_d[wr_addr_i[w]] = 1'b0;
      end
      if (alloc_en_i && gpr_ok(alloc_addr_i)) busy_d[alloc_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    wr_hit    = '0;
    alloc_hit = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[r])) wr_hit[r] = 1'b1;
      end
      alloc_hit[r] = alloc_en_i && (alloc_addr_i == rd_addr_i[r]);
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (gpr_ok(rd_addr_i[r])) begin
        rd_busy_o[r] = busy_q[rd_addr_i[r]];
        if ((BYPASS != 0) && wr_hit[r] && !alloc_hit[r]) rd_busy_o[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port GPR file with write bypass, busy scoreboard and privileged state
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  parameter int PC_W     = 32,
  parameter int XADDR_W  = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
  output logic [NUM_RD-1:0]              rd_busy_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
  input  logic                           alloc_en_i,
  input  logic [ADDR_W-1:0]              alloc_addr_i,
  input  logic                           iret_instr_i,
  input  logic                           xcpt_valid_i,
  input  xcpt_type_t                     xcpt_type_i,
  input  logic [PC_W-1:0]                rm_pc_i,
  input  logic [XADDR_W-1:0]             rm_addr_i,
  output priv_mode_t                     priv_mode_o,
  output logic [DATA_W-1:0]              rm0_data_o,
  output logic [DATA_W-1:0]              rm1_data_o,
  output logic [DATA_W-1:0]              rm2_data_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]               rm0_q, rm0_d;
  logic [DATA_W-1:0]               rm1_q, rm1_d;
  xcpt_type_t                      rm2_q, rm2_d;
  priv_mode_t                      priv_q, priv_d;

  function automatic logic gpr_ok(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Ascending port order lets the highest-index writer win on a collision.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && gpr_ok(wr_addr_i[w])) regs_d[wr_addr_i[w]] = wr_data_i[w];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (gpr_ok(rd_addr_i[r])) begin
        rd_data_o[r] = regs_q[rd_addr_i[r]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[r])) rd_data_o[r] = wr_data_i[w];
          end
        end
      end
    end
  end

  // An exception overrides a same-cycle iret and always lands in supervisor mode.
  always_comb begin
    rm0_d  = rm0_q;
    rm1_d  = rm1_q;
    rm2_d  = rm2_q;
    priv_d = priv_q;
    if (xcpt_valid_i) begin
      rm0_d  = DATA_W'(rm_pc_i);
      rm1_d  = DATA_W'(rm_addr_i);
      rm2_d  = xcpt_type_i;
      priv_d = PRIV_SUPERVISOR;
    end else if (iret_instr_i) begin
      priv_d = PRIV_USER;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rm0_q  <= '0;
      rm1_q  <= '0;
      rm2_q  <= XCPT_NONE;
      priv_q <= PRIV_RESET;
    end else begin
      rm0_q  <= rm0_d;
      rm1_q  <= rm1_d;
      rm2_q  <= rm2_d;
      priv_q <= priv_d;
    end
  end

  assign rm0_data_o  = rm0_q;
  assign rm1_data_o  = rm1_q;
  assign rm2_data_o  = DATA_W'(rm2_q);
  assign priv_mode_o = priv_q;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .flush_i      (xcpt_valid_i),
    .rd_addr_i    (rd_addr_i),
    .rd_busy_o    (rd_busy_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (plain and zero-register variants)
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             alloc_en;
  logic [4:0]       alloc_addr;
  logic             iret;
  logic             xcpt;
  xcpt_type_t       xtype;
  logic [31:0]      rmpc;
  logic [31:0]      rmaddr;

  logic [1:0][31:0] rd_data_a, rd_data_z;
  logic [1:0]       rd_busy_a, rd_busy_z;
  priv_mode_t       priv_a, priv_z;
  logic [31:0]      rm0_a, rm1_a, rm2_a, rm0_z, rm1_z, rm2_z;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];
  logic [31:0] m_rm0  [2];
  logic [31:0] m_rm1  [2];
  logic [31:0] m_rm2  [2];
  logic        m_priv [2];

  always #5 clk = ~clk;

  reg_file_mp #(.ZERO_REG(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
    .alloc_addr_i(alloc_addr), .iret_instr_i(iret), .xcpt_valid_i(xcpt), .xcpt_type_i(xtype),
    .rm_pc_i(rmpc), .rm_addr_i(rmaddr), .priv_mode_o(priv_a), .rm0_data_o(rm0_a),
    .rm1_data_o(rm1_a), .rm2_data_o(rm2_a)
  );

  reg_file_mp #(.ZERO_REG(1)) dut_z (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z), .rd_busy_o(rd_busy_z),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
    .alloc_addr_i(alloc_addr), .iret_instr_i(iret), .xcpt_valid_i(xcpt), .xcpt_type_i(xtype),
    .rm_pc_i(rmpc), .rm_addr_i(rmaddr), .priv_mode_o(priv_z), .rm0_data_o(rm0_z),
    .rm1_data_o(rm1_z), .rm2_data_o(rm2_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: variant 1 treats r0 as hardwired zero.
  always @(posedge clk or posedge rst) begin
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[z][i]  <= '0;
          m_busy[z][i] <= 1'b0;
        end
        m_rm0[z]  <= '0;
        m_rm1[z]  <= '0;
        m_rm2[z]  <= '0;
        m_priv[z] <= 1'b1;
      end else begin
        for (int w = 0; w < 2; w++)
          if (wr_en[w] && !(z == 1 && wr_addr[w] == 0)) m_mem[z][wr_addr[w]] <= wr_data[w];
        if (xcpt) begin
          for (int i = 0; i < 32; i++) m_busy[z][i] <= 1'b0;
          m_rm0[z]  <= rmpc;
          m_rm1[z]  <= rmaddr;
          m_rm2[z]  <= 32'(xtype);
          m_priv[z] <= 1'b1;
        end else begin
          for (int w = 0; w < 2; w++) if (wr_en[w]) m_busy[z][wr_addr[w]] <= 1'b0;
          if (alloc_en) m_busy[z][alloc_addr] <= 1'b1;
          if (z == 1) m_busy[z][0] <= 1'b0;
          if (iret) m_priv[z] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(int z, int r);
    logic [4:0]  a = rd_addr[r];
    logic [31:0] v;
    if (z == 1 && a == 0) return '0;
    v = m_mem[z][a];
    for (int w = 0; w < 2; w++) if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
    return v;
  endfunction

  function automatic logic exp_busy(int z, int r);
    logic [4:0] a = rd_addr[r];
    logic       b;
    if (z == 1 && a == 0) return 1'b0;
    b = m_busy[z][a];
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w] == a && !(alloc_en && alloc_addr == a)) b = 1'b0;
    return b;
  endfunction

  always @(negedge clk) begin
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("z%0d_rd_data%0d", z, r), z ? rd_data_z[r] : rd_data_a[r], exp_data(z, r));
        chk($sformatf("z%0d_rd_busy%0d", z, r), 32'(z ? rd_busy_z[r] : rd_busy_a[r]), 32'(exp_busy(z, r)));
      end
      chk($sformatf("z%0d_priv", z), 32'(z ? priv_z : priv_a), 32'(m_priv[z]));
      chk($sformatf("z%0d_rm0", z), z ? rm0_z : rm0_a, m_rm0[z]);
      chk($sformatf("z%0d_rm1", z), z ? rm1_z : rm1_a, m_rm1[z]);
      chk($sformatf("z%0d_rm2", z), z ? rm2_z : rm2_a, m_rm2[z]);
    end
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 0; alloc_addr = '0;
    iret = 0; xcpt = 0; xtype = XCPT_NONE; rmpc = '0; rmaddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd31;
    #12;
    chk("reset_rd_data0", rd_data_a[0], 32'h0);
    chk("reset_rd_data1", rd_data_a[1], 32'h0);
    chk("reset_rd_busy", 32'(rd_busy_a), 32'h0);
    chk("reset_priv", 32'(priv_a), 32'(PRIV_SUPERVISOR));
    rst = 1'b0;
    tick();

    wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'hAAAA0000; wr_data[1] = 32'h0000BBBB; rd_addr[0] = 5'd7;
    #1 chk("bypass_same_cycle", rd_data_a[0], 32'h0000BBBB);
    tick();
    idle();
    #1 chk("stored_after_collision", rd_data_a[0], 32'h0000BBBB);

    rd_addr[0] = 5'd3; alloc_en = 1; alloc_addr = 5'd3;
    tick();
    idle();
    #1 chk("alloc_sets_busy", 32'(rd_busy_a[0]), 32'h1);
    tick();
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h42;
    #1 chk("wr_bypass_busy", 32'(rd_busy_a[0]), 32'h0);
    chk("wr_bypass_data", rd_data_a[0], 32'h42);
    tick();
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h43; alloc_en = 1; alloc_addr = 5'd3;
    tick();
    idle();
    #1 chk("alloc_wins_over_wr", 32'(rd_busy_a[0]), 32'h1);
    chk("alloc_wr_data", rd_data_a[0], 32'h43);

    rd_addr[0] = 5'd4; rd_addr[1] = 5'd3; alloc_en = 1; alloc_addr = 5'd4;
    tick();
    idle();
    xcpt = 1; rmpc = 32'h1000; rmaddr = 32'hDEAD; xtype = XCPT_DTLB_MISS; iret = 1;
    alloc_en = 1; alloc_addr = 5'd5; wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
    tick();
    idle();
    #1 chk("xcpt_rm0", rm0_a, 32'h1000);
    chk("xcpt_rm1", rm1_a, 32'hDEAD);
    chk("xcpt_rm2", rm2_a, 32'h2);
    chk("xcpt_priv", 32'(priv_a), 32'(PRIV_SUPERVISOR));
    chk("xcpt_clears_r4", 32'(rd_busy_a[0]), 32'h0);
    chk("xcpt_clears_r3", 32'(rd_busy_a[1]), 32'h0);
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd9;
    #1 chk("xcpt_drops_alloc", 32'(rd_busy_a[0]), 32'h0);
    chk("xcpt_wr_commits", rd_data_a[1], 32'h99);

    iret = 1;
    tick();
    chk("iret_user", 32'(priv_a), 32'(PRIV_USER));
    tick();
    chk("iret_stays_user", 32'(priv_a), 32'(PRIV_USER));
    idle();

    rd_addr[0] = 5'd0; wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h55;
    #1 chk("zero_bypass_z", rd_data_z[0], 32'h0);
    chk("zero_bypass_a", rd_data_a[0], 32'h55);
    tick();
    idle();
    alloc_en = 1; alloc_addr = 5'd0;
    tick();
    idle();
    #1 chk("zero_read_z", rd_data_z[0], 32'h0);
    chk("zero_busy_z", 32'(rd_busy_z[0]), 32'h0);
    chk("zero_busy_a", 32'(rd_busy_a[0]), 32'h1);

    rd_addr[1] = 5'd10; alloc_en = 1; alloc_addr = 5'd10;
    tick();
    idle();
    #1 chk("pre_reset_busy", 32'(rd_busy_a[1]), 32'h1);
    #1 rst = 1'b1;
    #1 chk("async_rst_busy", 32'(rd_busy_a), 32'h0);
    chk("async_rst_data", rd_data_a[0], 32'h0);
    chk("async_rst_priv", 32'(priv_a), 32'(PRIV_SUPERVISOR));
    chk("async_rst_rm0", rm0_a, 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rd_addr[0] = 5'($urandom_range(0, 7)); rd_addr[1] = 5'($urandom_range(0, 7));
      wr_en = 2'($urandom_range(0, 3));
      wr_addr[0] = 5'($urandom_range(0, 7)); wr_addr[1] = 5'($urandom_range(0, 7));
      wr_data[0] = $urandom; wr_data[1] = $urandom;
      alloc_en = 1'($urandom_range(0, 1)); alloc_addr = 5'($urandom_range(0, 7));
      xcpt = ($urandom_range(0, 9) == 0); iret = ($urandom_range(0, 5) == 0);
      xtype = xcpt_type_t'($urandom_range(0, 6)); rmpc = $urandom; rmaddr = $urandom;
      tick();
    end
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the decode-stage register file.
- Provides N read ports with write-to-read bypass, M write-back ports, and a per-register busy scoreboard for decode hazard detection.
- Holds the privileged state: rm0 (exception PC), rm1 (fault address), rm2 (exception type) and privilege mode.
- Sits in decode; write-back ports are driven from the ALU/MEM/MUL pipes.

Parameters:
- NUM_REGS, 32: number of architectural GPRs; ADDR_W = $clog2(NUM_REGS).
- DATA_W, 32: GPR and rm0/rm1 width.
- NUM_RD, 2: read ports.
- NUM_WR, 2: write-back ports; a higher index has higher priority.
- BYPASS, 1: when 1, same-cycle write data is forwarded to reads.
- ZERO_REG, 0: when 1, r0 reads as 0, ignores writes and is never busy.
- PC_W, 32: rmPC width. XADDR_W, 32: rmAddr width. Both are zero-extended to DATA_W.

Ports:
- clock, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- rd_addr, in, NUM_RD x ADDR_W: read addresses.
- rd_data, out, NUM_RD x DATA_W: read data.
- rd_busy, out, NUM_RD: the addressed register has a pending producer.
- wr_en, in, NUM_WR: write-back enables.
- wr_addr, in, NUM_WR x ADDR_W: write-back destinations.
- wr_data, in, NUM_WR x DATA_W: write-back data.
- alloc_en, in, 1: decode issued an instruction with a destination.
- alloc_addr, in, ADDR_W: destination to mark busy.
- iret_instr, in, 1: return from exception.
- xcpt_valid, in, 1: exception commit.
- xcpt_type, in, xcpt_type_t: exception cause.
- rmPC, in, PC_W: faulting PC.
- rmAddr, in, XADDR_W: faulting address.
- priv_mode, out, priv_mode_t: current privilege mode.
- rm0_data, rm1_data, rm2_data, out, DATA_W: privileged register values.

Behaviour:
- Reset (async, immediate):
  - All GPRs = 0, busy = 0, rm0/rm1/rm2 = 0.
  - priv_mode = Supervisor.
  - rd_data = 0 (all GPRs are 0), rd_busy = 0.
- Reads are combinational with zero latency.
  - With BYPASS=1, rd_data returns the highest-index wr port whose wr_en is set and wr_addr matches; otherwise the stored value.
  - With BYPASS=0, rd_data returns the stored value only.
  - With ZERO_REG=1 and rd_addr=0, rd_data is 0.
- Writes commit on the clock edge.
  - If several ports target the same address, the highest index wins.
  - With ZERO_REG=1, writes to r0 are dropped.
- Scoreboard: one busy bit per register, updated at the edge.
  - A write clears the bit of wr_addr; alloc sets the bit of alloc_addr.
  - If alloc and write hit the same register in the same cycle, alloc wins and the bit stays 1, because a new producer has been issued.
  - rd_busy = busy_ff[rd_addr]. With BYPASS=1, rd_busy is cleared when a same-cycle write matches and no alloc hits that register in the same cycle.
- Exception (xcpt_valid=1), effective at the edge:
  - rm0 = zext(rmPC), rm1 = zext(rmAddr), rm2 = xcpt_type, priv = Supervisor.
  - All busy bits clear: the pipe is flushed and alloc in that cycle is ignored.
  - GPR writes in the same cycle still commit, since they are older instructions.
- iret_instr with no exception sets priv = User.
  - If xcpt_valid and iret_instr are both 1, the exception wins.
  - iret while already in User: priv stays User.
- rm*_data and priv_mode are driven directly from flops, with no bypass; the new value is visible the cycle after the event.
- Reset asserted mid-operation discards all pending state, including busy bits.
- Out-of-range addresses (NUM_REGS not a power of 2) read 0 and are not busy; writes and allocs to them are ignored.

Decomposition:
- Shared package (soc.vh / core package) holds:
  - existing xcpt_type_t and priv_mode_t (User, Supervisor);
  - REG_FILE_* range macros, redefined from NUM_REGS/DATA_W;
  - the RST_FF macro, already async.
- Sub-module reg_scoreboard (NUM_REGS, NUM_WR, NUM_RD) contains the busy bits, the alloc/release/flush logic and the rd_busy lookup.
- The data array, bypass mux and privileged registers stay in reg_file_mp.

Test Plan:
- Reset then read: reset pulse, rd_addr={5,31} -> rd_data={0,0}, rd_busy=0, priv_mode=Supervisor.
- Bypass and ordering (BYPASS=1):
  - wr0 (addr 7, data 0xAAAA0000) and wr1 (addr 7, data 0x0000BBBB) in the same cycle, rd_addr0=7 -> same-cycle rd_data=0x0000BBBB.
  - Next cycle the stored value is 0x0000BBBB.
- Scoreboard:
  - alloc r3 at cycle 0 -> rd_busy=1 on r3 at cycle 1.
  - wr r3 (0x42) at cycle 2 -> rd_busy=0 in the same cycle (bypass) and rd_data=0x42.
  - alloc r3 and wr r3 in the same cycle -> busy remains 1.
- Exception:
  - Setup: r4 allocated; xcpt_valid with rmPC=0x1000, rmAddr=0xDEAD, type=dTLB_miss, and iret_instr=1 in the same cycle.
  - Result: rm0=0x1000, rm1=0xDEAD, rm2=dTLB_miss, priv=Supervisor, busy(r4)=0.
- iret: xcpt_valid=0, iret_instr=1 -> priv_mode=User next cycle; a second iret leaves it User.
- ZERO_REG=1: write 0x55 to r0 -> read r0=0; alloc r0 -> rd_busy=0.
- Async reset mid-operation: assert reset between edges with busy bits set -> outputs and busy return to reset values immediately, without waiting for a clock edge.
